ws2812_stream_driver: RTL and testbench

- Downstream consumer of the Nios system's two 24-bit frequency-band colour exports, freqsep_1_export and freqsep_2_export.
- Serialises them onto a single-wire WS2812 LED chain: first group of LEDs shows band 1, second group shows band 2.
- Snapshots both words once per frame, so a Nios write mid-frame never tears a frame.
- Runs in the same clock domain as the processor system.

---
 rtl/ws2812_pkg.sv | 36 +++
 rtl/ws2812_stream_driver_bit_timer.sv | 52 +++++
 rtl/ws2812_stream_driver.sv | 148 ++++++++++++++
 tb/tb_ws2812_stream_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, timing defaults and colour helpers for the WS2812 stream driver.
// Optional brightness scaling is compiled in with WS2812_BRIGHTNESS_EN.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_HI,
        BIT_LO,
        GAP
    } state_t;

    // Defaults for a 50 MHz system clock
    localparam int DEF_LEDS_PER_GROUP = 8;
    localparam int DEF_T0H_CYC        = 20;
    localparam int DEF_T1H_CYC        = 40;
    localparam int DEF_TBIT_CYC       = 63;
    localparam int DEF_TRST_CYC       = 15000;

    localparam int WORD_W = 24;

    // Nios exports are packed R,G,B; the LEDs expect G,R,B on the wire
    function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

`ifdef WS2812_BRIGHTNESS_EN
    // (c * (b + 1)) >> 8: b=255 leaves c unchanged, b=0 blanks it
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = 17'(c) * 17'({1'b0, b} + 9'd1);
        return p[15:8];
    endfunction
`endif

endpackage

// File: rtl/ws2812_stream_driver_bit_timer.sv
// One WS2812 bit slot: high for THI cycles, low for the rest of TBIT_CYC.
// A start in the final low cycle chains the next bit with no idle gap.
module ws2812_bit_timer #(
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic hi_last,
    output logic bit_done
);

    localparam int CW = $clog2(TBIT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] T0H  = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H  = CW'(T1H_CYC);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] thi;

    assign bit_done = active && (cnt == LAST);
    assign hi_last  = active && (cnt == thi - CW'(1));

    // Count through the bit slot; dout is registered so it is glitch-free on the pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            thi    <= '0;
            dout   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            thi    <= bit_val ? T1H : T0H;
            dout   <= 1'b1;
        end else if (active) begin
            if (bit_done) begin
                active <= 1'b0;
                dout   <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                dout <= (cnt + CW'(1)) < thi;
            end
        end
    end

endmodule

// File: rtl/ws2812_stream_driver.sv
// Serialises two 24-bit band colours onto a WS2812 chain: the first
// LEDS_PER_GROUP LEDs show band 1, the next LEDS_PER_GROUP show band 2.
// Both words are snapshotted once per frame so CPU writes never tear a frame.
// Define WS2812_BRIGHTNESS_EN to add a brightness[7:0] scaling input.
module ws2812_stream_driver
    import ws2812_pkg::*;
#(
    parameter int LEDS_PER_GROUP = DEF_LEDS_PER_GROUP,
    parameter int T0H_CYC        = DEF_T0H_CYC,
    parameter int T1H_CYC        = DEF_T1H_CYC,
    parameter int TBIT_CYC       = DEF_TBIT_CYC,
    parameter int TRST_CYC       = DEF_TRST_CYC
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [23:0] freqsep_1_export,
    input  logic [23:0] freqsep_2_export,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]  brightness,
`endif
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int NLED = 2 * LEDS_PER_GROUP;
    localparam int LW   = (NLED > 1) ? $clog2(NLED) : 1;
    localparam int CMAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [LW-1:0] GRP      = LW'(LEDS_PER_GROUP);
    localparam logic [LW-1:0] LAST_LED = LW'(NLED - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(TRST_CYC - 1);

    generate
        if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC &&
              LEDS_PER_GROUP >= 1 && TRST_CYC >= 1)) begin : g_bad_params
            $error("ws2812_stream_driver: need 0<T0H_CYC<T1H_CYC<TBIT_CYC, LEDS_PER_GROUP>=1, TRST_CYC>=1");
        end
    endgenerate

    state_t         state;
    logic [23:0]    snap1, snap2;
    logic [23:0]    snap1_nxt, snap2_nxt;
    logic [LW-1:0]  led_cnt, nxt_led;
    logic [4:0]     bit_cnt, nxt_bit;
    logic [CW-1:0]  cyc;
    logic [23:0]    nxt_word;
    logic           bit_last, frame_last;
    logic           tmr_start, tmr_bit, tmr_hi_last, tmr_done;

    // Next snapshot values (optionally brightness-scaled) and next-bit selection
    always_comb begin
`ifdef WS2812_BRIGHTNESS_EN
        snap1_nxt = rgb_to_grb({scale8(freqsep_1_export[23:16], brightness),
                                scale8(freqsep_1_export[15:8],  brightness),
                                scale8(freqsep_1_export[7:0],   brightness)});
        snap2_nxt = rgb_to_grb({scale8(freqsep_2_export[23:16], brightness),
                                scale8(freqsep_2_export[15:8],  brightness),
                                scale8(freqsep_2_export[7:0],   brightness)});
`else
        snap1_nxt = rgb_to_grb(freqsep_1_export);
        snap2_nxt = rgb_to_grb(freqsep_2_export);
`endif
        bit_last   = (bit_cnt == 5'd0);
        nxt_bit    = bit_last ? 5'd23 : bit_cnt - 5'd1;
        nxt_led    = bit_last ? led_cnt + LW'(1) : led_cnt;
        frame_last = bit_last && (led_cnt == LAST_LED);
        nxt_word   = (nxt_led < GRP) ? snap1 : snap2;
        // The first bit comes straight from the word being captured this cycle
        tmr_start  = (state == LOAD) || (state == BIT_LO && tmr_done && !frame_last);
        tmr_bit    = (state == LOAD) ? snap1_nxt[23] : nxt_word[nxt_bit];
    end

    ws2812_bit_timer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_timer (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .start    (tmr_start),
        .bit_val  (tmr_bit),
        .dout     (led_dout),
        .hi_last  (tmr_hi_last),
        .bit_done (tmr_done)
    );

    // Frame sequencer: snapshot, walk LEDs/bits MSB first, then the latch gap
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            snap1      <= '0;
            snap2      <= '0;
            led_cnt    <= '0;
            bit_cnt    <= '0;
            cyc        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    snap1   <= snap1_nxt;
                    snap2   <= snap2_nxt;
                    led_cnt <= '0;
                    bit_cnt <= 5'd23;
                    cyc     <= '0;
                    state   <= BIT_HI;
                end
                BIT_HI: begin
                    if (tmr_hi_last) state <= BIT_LO;
                end
                BIT_LO: begin
                    if (tmr_done) begin
                        if (frame_last) begin
                            state      <= GAP;
                            cyc        <= '0;
                            frame_done <= (TRST_CYC == 1);
                        end else begin
                            bit_cnt <= nxt_bit;
                            led_cnt <= nxt_led;
                            state   <= BIT_HI;
                        end
                    end
                end
                GAP: begin
                    if (cyc == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cyc        <= cyc + CW'(1);
                        frame_done <= ((cyc + CW'(1)) == GAP_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Directed bench for ws2812_stream_driver with small timing parameters.
// Expected GRB words are queued when a frame is launched; a monitor decodes
// the wire from high-pulse widths and the words are compared after each frame.
module tb_ws2812_stream_driver;

    localparam int L  = 2;
    localparam int T0 = 2;
    localparam int T1 = 4;
    localparam int TB = 6;
    localparam int TR = 10;
    localparam int BUSY_CYC  = 1 + 48 * L * TB + TR;   // 587
    localparam int FRAME_CYC = BUSY_CYC + 1;           // 588

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] f1 = '0;
    logic [23:0] f2 = '0;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'hFF;
`endif
    logic        led_dout, busy, frame_done;

    always #5 clk_clk = ~clk_clk;

    ws2812_stream_driver #(
        .LEDS_PER_GROUP (L),
        .T0H_CYC        (T0),
        .T1H_CYC        (T1),
        .TBIT_CYC       (TB),
        .TRST_CYC       (TR)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .enable           (enable),
        .freqsep_1_export (f1),
        .freqsep_2_export (f2),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness       (brightness),
`endif
        .led_dout         (led_dout),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] got_mem [0:63];
    int          got_wr = 0;
    int          got_rd = 0;
    int          bad_width = 0;

    int          hcnt = 0;
    int          nbits = 0;
    logic        prev = 1'b0;
    logic [22:0] shreg = '0;

    // Wire decoder: width of each high pulse gives the bit, 24 bits make a word
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            prev  <= 1'b0;
            hcnt  <= 0;
            nbits <= 0;
        end else begin
            prev <= led_dout;
            if (led_dout) begin
                hcnt <= hcnt + 1;
            end else if (prev) begin
                hcnt <= 0;
                if (hcnt != T0 && hcnt != T1) bad_width <= bad_width + 1;
                if (nbits == 23) begin
                    if (got_wr < 64) got_mem[got_wr] <= {shreg, hcnt == T1};
                    got_wr <= got_wr + 1;
                    nbits  <= 0;
                end else begin
                    shreg <= {shreg[21:0], hcnt == T1};
                    nbits <= nbits + 1;
                end
            end
        end
    end

    function automatic logic [23:0] grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < L; i++) exp_q.push_back(grb(a));
        for (int i = 0; i < L; i++) exp_q.push_back(grb(b));
    endtask

    // Follow one enable-pulsed frame to its end; enable drops in the LOAD cycle
    task automatic watch_frame(output int bc, output int fc, output int first_hi);
        bit done;
        bc = 0; fc = 0; first_hi = 0; done = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk_clk);
            if (i == 1) enable = 1'b0;
            if (busy) bc++;
            if (frame_done) fc++;
            if (led_dout && first_hi == 0) first_hi = i;
            if (!busy && bc > 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("frame_finished", 32'(done), 32'd1);
    endtask

    // Compare every queued word against what came off the wire
    task automatic drain(input string tag);
        logic [23:0] e;
        bit present;
        while (exp_q.size() > 0) begin
            present = (got_rd < got_wr);
            chk({tag, "_word_present"}, 32'(present), 32'd1);
            if (!present) begin
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            chk({tag, "_word"}, 32'(got_mem[got_rd]), 32'(e));
            got_rd++;
        end
        chk({tag, "_extra_words"}, 32'(got_wr - got_rd), 32'd0);
        chk({tag, "_pulse_width"}, 32'(bad_width), 32'd0);
    endtask

    initial begin
        int bc, fc, fh, t, nfd;
        int fdt [0:2];

        // Reset state
        repeat (3) @(negedge clk_clk);
        chk("reset_outputs", 32'({led_dout, busy, frame_done}), 32'd0);
        reset_reset_n = 1'b1;

        // Idle with enable low: nothing moves
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_clk);
            chk("idle_outputs", 32'({led_dout, busy, frame_done}), 32'd0);
        end

        // Single frame, enable pulsed for one cycle
        f1 = 24'hFF0000;
        f2 = 24'h0000FF;
        exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'h0000FF);
        exp_q.push_back(24'h0000FF);
        enable = 1'b1;
        watch_frame(bc, fc, fh);
        chk("f1_busy_cycles", 32'(bc), 32'(BUSY_CYC));
        chk("f1_frame_done_pulses", 32'(fc), 32'd1);
        chk("f1_first_high_cycle", 32'(fh), 32'd2);
        drain("f1");
        repeat (5) @(negedge clk_clk);
        chk("f1_back_to_idle", 32'({led_dout, busy}), 32'd0);

        // Back-to-back frames; band 1 rewritten mid-frame, enable dropped in frame 3
        f1 = 24'hA1B2C3;
        f2 = 24'h0F0E0D;
        push_frame(24'hA1B2C3, 24'h0F0E0D);
        push_frame(24'h123456, 24'h0F0E0D);
        push_frame(24'h123456, 24'h0F0E0D);
        enable = 1'b1;
        t = 0;
        nfd = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_clk);
            t++;
            if (t == 2 + 5 * TB + 2) f1 = 24'h123456;
            if (frame_done) begin
                if (nfd < 3) fdt[nfd] = t;
                nfd++;
            end
            if (nfd == 2 && t == fdt[1] + 5) enable = 1'b0;
            if (nfd >= 3 && !busy) break;
        end
        enable = 1'b0;
        chk("b2b_frame_count", 32'(nfd), 32'd3);
        chk("b2b_first_done_time", 32'(fdt[0]), 32'(BUSY_CYC));
        chk("b2b_period_1", 32'(fdt[1] - fdt[0]), 32'(FRAME_CYC));
        chk("b2b_period_2", 32'(fdt[2] - fdt[1]), 32'(FRAME_CYC));
        repeat (10) @(negedge clk_clk);
        chk("b2b_idle_after_disable", 32'({led_dout, busy, frame_done}), 32'd0);
        drain("b2b");

        // Reset while the line is high mid-bit
        f1 = 24'hFFFFFF;
        f2 = 24'hFFFFFF;
        enable = 1'b1;
        for (int i = 1; i <= 2 + 3 * TB + 1; i++) begin
            @(negedge clk_clk);
            if (i == 1) enable = 1'b0;
        end
        chk("pre_reset_line_high", 32'({led_dout, busy}), 32'b11);
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("reset_mid_bit", 32'({led_dout, busy}), 32'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        chk("after_reset_idle", 32'({led_dout, busy, frame_done}), 32'd0);

        // Fresh frame after reset must be bit-exact
        f1 = 24'h0C3F81;
        f2 = 24'hE7007E;
        push_frame(f1, f2);
        enable = 1'b1;
        watch_frame(bc, fc, fh);
        chk("pr_busy_cycles", 32'(bc), 32'(BUSY_CYC));
        chk("pr_frame_done_pulses", 32'(fc), 32'd1);
        chk("pr_first_high_cycle", 32'(fh), 32'd2);
        drain("pr");

`ifdef WS2812_BRIGHTNESS_EN
        // Half brightness
        brightness = 8'd127;
        f1 = 24'hFF8040;
        f2 = 24'hFF8040;
        for (int i = 0; i < 2 * L; i++) exp_q.push_back(24'h407F20);
        enable = 1'b1;
        watch_frame(bc, fc, fh);
        chk("br127_busy_cycles", 32'(bc), 32'(BUSY_CYC));
        drain("br127");

        // Zero brightness blanks everything with unchanged timing
        brightness = 8'd0;
        f1 = 24'hA1B2C3;
        f2 = 24'hFFFFFF;
        for (int i = 0; i < 2 * L; i++) exp_q.push_back(24'h000000);
        enable = 1'b1;
        watch_frame(bc, fc, fh);
        chk("br0_busy_cycles", 32'(bc), 32'(BUSY_CYC));
        chk("br0_frame_done_pulses", 32'(fc), 32'd1);
        drain("br0");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
